// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI responder
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_serf_state_t;

  localparam int SPI_FRAME_BITS = 16;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with level, rise and fall pulse outputs
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_serf.sv
// rtl/spi_serf.sv - oversampling 16-bit SPI responder; SPI_SERF_FRMERR_EN adds frm_err
module spi_serf
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      SS_n,
  input  logic                      SCLK,
  input  logic                      MOSI,
  output logic                      MISO,
  input  logic                      wrt,
  input  logic [SPI_FRAME_BITS-1:0] tx_data,
  output logic [SPI_FRAME_BITS-1:0] rx_data,
`ifdef SPI_SERF_FRMERR_EN
  output logic                      frm_err,
`endif
  output logic                      rdy
);

  localparam int W = SPI_FRAME_BITS;

  logic w_sclk_level, w_sclk_rise, w_sclk_fall;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_serf_state_t r_state, w_state_nxt;
  logic [W-1:0]    r_shft, w_shft_nxt;
  logic            r_rdy, w_rdy_nxt;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .i_d(SCLK),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst_n(rst_n), .i_d(SS_n),
    .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  // Same depth as SCLK so the level seen on a detected rise is the bit the monarch set up
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst_n(rst_n), .i_d(MOSI),
    .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  assign w_unused = ^{w_sclk_level, w_sclk_fall, w_ss_level, w_mosi_rise, w_mosi_fall};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shft  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shft  <= w_shft_nxt;
      r_rdy   <= w_rdy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shft_nxt  = r_shft;
    w_rdy_nxt   = r_rdy;
    case (r_state)
      IDLE: begin
        if (wrt) begin
          w_shft_nxt = tx_data;
          w_rdy_nxt  = 1'b0;
        end
        if (w_ss_fall) begin
          w_state_nxt = ACTIVE;
          w_rdy_nxt   = 1'b0;
        end
      end
      ACTIVE: begin
        // wrt is deliberately not decoded here so a mid-frame load cannot corrupt the reply
        if (w_sclk_rise) w_shft_nxt = {r_shft[W-2:0], w_mosi};
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          w_rdy_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

`ifdef SPI_SERF_FRMERR_EN
  logic [4:0] r_rise_cnt, w_rise_cnt_nxt, w_rise_cnt_inc;
  logic       r_frm_err, w_frm_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rise_cnt <= '0;
      r_frm_err  <= 1'b0;
    end else begin
      r_rise_cnt <= w_rise_cnt_nxt;
      r_frm_err  <= w_frm_err_nxt;
    end
  end

  // Saturating so over-long frames never alias back to a legal count
  assign w_rise_cnt_inc = (w_sclk_rise && r_rise_cnt != 5'd31) ? r_rise_cnt + 5'd1 : r_rise_cnt;

  always_comb begin
    w_rise_cnt_nxt = r_rise_cnt;
    w_frm_err_nxt  = r_frm_err;
    if (r_state == IDLE) begin
      if (wrt) w_frm_err_nxt = 1'b0;
      if (w_ss_fall) begin
        w_rise_cnt_nxt = '0;
        w_frm_err_nxt  = 1'b0;
      end
    end else begin
      w_rise_cnt_nxt = w_rise_cnt_inc;
      if (w_ss_rise) w_frm_err_nxt = (w_rise_cnt_inc != 5'(SPI_FRAME_BITS));
    end
  end

  assign frm_err = r_frm_err;
`endif

  assign MISO    = r_shft[W-1];
  assign rx_data = r_shft;
  assign rdy     = r_rdy;

endmodule
